// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - hazard detection and operand forwarding control for the 5-stage pipeline
//
// Tracks destination info of the instructions in EX, MEM and WB in a private
// shadow pipeline and feeds decisions back into ID and IF.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rs, id_rt               source registers of the ID instruction
//   id_uses_rs, id_uses_rt     ID instruction actually reads rs / rt
//   id_dest, id_rf_enable      destination register and write enable of the ID instruction
//   id_load                    ID instruction is a load
//   branch_taken               taken branch/jump resolved in EX this cycle
//   fwd_a_sel, fwd_b_sel       operand mux selects: 00 RF, 01 EX, 10 MEM, 11 WB
//   pc_enable, ifid_enable     PC and IF/ID register may advance
//   flush_ifid                 IF/ID loads a NOP next edge
//   idex_bubble                ID/EX loads all-zero control next edge
//   stall_count, flush_count   saturating load-use stall / branch flush cycle counters

module hazard_fwd_ctrl #(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_rf_enable,
    input  logic             id_load,
    input  logic             branch_taken,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             flush_ifid,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       rf_en;
        logic       load;
    } slot_t;

    slot_t ex_slot;
    slot_t mem_slot;
    slot_t wb_slot;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Register 0 is hardwired to zero, so a write to it never produces a value to forward.
    function automatic logic slot_writes(input slot_t s, input logic [4:0] r);
        return s.valid && s.rf_en && (s.dest == r) && (r != 5'd0);
    endfunction

    // A load in EX has no data yet, so it cannot be an EX-stage source; the search
    // falls through to the older slots and the load-use stall covers the gap.
    function automatic logic [1:0] select_for(input logic used, input logic [4:0] r,
                                              input slot_t ex, input slot_t mem,
                                              input slot_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (used) begin
            if (slot_writes(ex, r) && !ex.load) begin
                sel = 2'b01;
            end else if (slot_writes(mem, r)) begin
                sel = 2'b10;
            end else if (slot_writes(wb, r)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    logic lu;
    logic br;

    always_comb begin
        fwd_a_sel = select_for(id_uses_rs, id_rs, ex_slot, mem_slot, wb_slot);
        fwd_b_sel = select_for(id_uses_rt, id_rt, ex_slot, mem_slot, wb_slot);
    end

    always_comb begin
        lu = ex_slot.load &&
             ((id_uses_rs && slot_writes(ex_slot, id_rs)) ||
              (id_uses_rt && slot_writes(ex_slot, id_rt)));
        br = branch_taken;
    end

    // A taken branch overrides a simultaneous load-use stall: the stalled
    // instruction is on the wrong path (or in the delay slot, which then
    // simply proceeds and is re-checked next cycle).
    always_comb begin
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        flush_ifid  = 1'b0;
        idex_bubble = 1'b0;
        if (br) begin
            flush_ifid  = 1'b1;
            idex_bubble = (DELAY_SLOT == 0);
        end else if (lu) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_slot     <= '0;
            mem_slot    <= '0;
            wb_slot     <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            wb_slot       <= mem_slot;
            mem_slot      <= ex_slot;
            ex_slot.valid <= !idex_bubble;
            ex_slot.dest  <= id_dest;
            ex_slot.rf_en <= id_rf_enable;
            ex_slot.load  <= id_load;
            if (lu && !br && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (br && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - self-checking bench for hazard_fwd_ctrl
//
// Two instances share the stimulus: u0 with a delay slot and 16-bit counters,
// u1 without a delay slot and 2-bit counters so saturation is reached quickly.
// A model keeps the in-flight instructions as a short history list per
// instance and is checked against both DUTs on every falling edge; directed
// literal checks pin the model at the interesting points.

module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_uses_rs = 1'b0;
    logic       id_uses_rt = 1'b0;
    logic [4:0] id_dest = '0;
    logic       id_rf_enable = 1'b0;
    logic       id_load = 1'b0;
    logic       branch_taken = 1'b0;

    logic [1:0]  fa [2];
    logic [1:0]  fb [2];
    logic        pc [2];
    logic        ie [2];
    logic        fl [2];
    logic        bb [2];
    logic [15:0] sc0, fc0;
    logic [1:0]  sc1, fc1;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.DELAY_SLOT(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load(id_load),
        .branch_taken(branch_taken),
        .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]), .pc_enable(pc[0]), .ifid_enable(ie[0]),
        .flush_ifid(fl[0]), .idex_bubble(bb[0]), .stall_count(sc0), .flush_count(fc0)
    );

    hazard_fwd_ctrl #(.DELAY_SLOT(0), .CNT_W(2)) u1 (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_rf_enable(id_rf_enable), .id_load(id_load),
        .branch_taken(branch_taken),
        .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]), .pc_enable(pc[1]), .ifid_enable(ie[1]),
        .flush_ifid(fl[1]), .idex_bubble(bb[1]), .stall_count(sc1), .flush_count(fc1)
    );

    int passed = 0;
    int total = 0;
    bit done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // History of issued instructions per instance, index 0 = youngest (EX).
    bit       hv [2][3];
    bit [4:0] hd [2][3];
    bit       hr [2][3];
    bit       hl [2][3];
    int       sc [2];
    int       fc [2];

    function automatic int cmax(input int m);
        return (m == 0) ? 65535 : 3;
    endfunction

    function automatic bit produces(input int m, input int k, input bit [4:0] r);
        return hv[m][k] && hr[m][k] && (hd[m][k] == r) && (r != 0);
    endfunction

    function automatic logic [1:0] m_fwd(input int m, input bit used, input bit [4:0] r);
        if (!used) return 2'b00;
        for (int k = 0; k < 3; k++)
            if (produces(m, k, r) && !(k == 0 && hl[m][k])) return 2'(k + 1);
        return 2'b00;
    endfunction

    function automatic bit m_lu(input int m);
        return hl[m][0] && ((id_uses_rs && produces(m, 0, id_rs)) ||
                            (id_uses_rt && produces(m, 0, id_rt)));
    endfunction

    function automatic bit m_bubble(input int m);
        if (branch_taken) return (m == 1);
        return m_lu(m);
    endfunction

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                for (int k = 0; k < 3; k++) hv[m][k] = 0;
                sc[m] = 0;
                fc[m] = 0;
            end else begin
                bit b;
                b = m_bubble(m);
                if (!branch_taken && m_lu(m) && sc[m] < cmax(m)) sc[m]++;
                if (branch_taken && fc[m] < cmax(m)) fc[m]++;
                for (int k = 2; k > 0; k--) begin
                    hv[m][k] = hv[m][k-1]; hd[m][k] = hd[m][k-1];
                    hr[m][k] = hr[m][k-1]; hl[m][k] = hl[m][k-1];
                end
                hv[m][0] = !b; hd[m][0] = id_dest; hr[m][0] = id_rf_enable; hl[m][0] = id_load;
            end
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit ur, input bit ut,
                         input logic [4:0] dest, input bit rf, input bit ld, input bit br);
        id_rs = rs; id_rt = rt; id_uses_rs = ur; id_uses_rt = ut;
        id_dest = dest; id_rf_enable = rf; id_load = ld; branch_taken = br;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!done) begin
                for (int m = 0; m < 2; m++) begin
                    chk($sformatf("u%0d fwd_a", m), 32'(fa[m]), 32'(m_fwd(m, id_uses_rs, id_rs)));
                    chk($sformatf("u%0d fwd_b", m), 32'(fb[m]), 32'(m_fwd(m, id_uses_rt, id_rt)));
                    chk($sformatf("u%0d pc_enable", m), 32'(pc[m]), 32'(branch_taken || !m_lu(m)));
                    chk($sformatf("u%0d ifid_enable", m), 32'(ie[m]), 32'(branch_taken || !m_lu(m)));
                    chk($sformatf("u%0d flush_ifid", m), 32'(fl[m]), 32'(branch_taken));
                    chk($sformatf("u%0d idex_bubble", m), 32'(bb[m]), 32'(m_bubble(m)));
                end
                chk("u0 stall_count", 32'(sc0), 32'(sc[0]));
                chk("u0 flush_count", 32'(fc0), 32'(fc[0]));
                chk("u1 stall_count", 32'(sc1), 32'(sc[1]));
                chk("u1 flush_count", 32'(fc1), 32'(fc[1]));
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        nxt(); nxt();
        @(negedge clk);
        chk("rst fwd_a", 32'(fa[0]), 32'd0);
        chk("rst fwd_b", 32'(fb[0]), 32'd0);
        chk("rst pc_enable", 32'(pc[0]), 32'd1);
        chk("rst ifid_enable", 32'(ie[0]), 32'd1);
        chk("rst counts", 32'({sc0, fc0}), 32'd0);
        nxt();
        reset = 1'b0;
        nxt();
        @(negedge clk);
        chk("idle bubble", 32'(bb[0]), 32'd0);

        // ADD r3 followed by three readers of r3
        drive(0, 0, 0, 0, 3, 1, 0, 0); nxt();
        drive(3, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("add fwd EX", 32'(fa[0]), 32'd1); nxt();
        @(negedge clk); chk("add fwd MEM", 32'(fa[0]), 32'd2); nxt();
        @(negedge clk); chk("add fwd WB", 32'(fa[0]), 32'd3); nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0); nxt(); nxt(); nxt();

        // LW r5 then use of rt=5
        drive(0, 0, 0, 0, 5, 1, 1, 0); nxt();
        drive(0, 5, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu pc_enable", 32'(pc[0]), 32'd0);
        chk("lu ifid_enable", 32'(ie[0]), 32'd0);
        chk("lu bubble", 32'(bb[0]), 32'd1);
        nxt();
        @(negedge clk);
        chk("lu resolved pc", 32'(pc[0]), 32'd1);
        chk("lu fwd_b MEM", 32'(fb[0]), 32'd2);
        chk("lu stall_count", 32'(sc0), 32'd1);
        nxt();

        // r0 writers, including a load, must never forward or stall
        drive(0, 0, 0, 0, 0, 1, 0, 0); nxt(); nxt();
        drive(0, 0, 0, 0, 0, 1, 1, 0); nxt();
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0 fwd_a", 32'(fa[0]), 32'd0);
        chk("r0 fwd_b", 32'(fb[0]), 32'd0);
        chk("r0 pc_enable", 32'(pc[0]), 32'd1);
        nxt();

        // taken branch together with a load-use hazard
        drive(0, 0, 0, 0, 7, 1, 1, 0); nxt();
        drive(7, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("br+lu flush", 32'(fl[0]), 32'd1);
        chk("br+lu bubble ds1", 32'(bb[0]), 32'd0);
        chk("br+lu pc_enable", 32'(pc[0]), 32'd1);
        chk("br+lu bubble ds0", 32'(bb[1]), 32'd1);
        nxt();
        drive(7, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("br flush_count", 32'(fc0), 32'd1);
        chk("br stall_count held", 32'(sc0), 32'd1);
        chk("br post fwd_a", 32'(fa[0]), 32'd2);
        nxt();

        // three more stalls: u1 saturates at 3, u0 reaches 4
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 6, 1, 1, 0); nxt();
            drive(0, 6, 0, 1, 0, 0, 0, 0); nxt(); nxt();
        end
        @(negedge clk);
        chk("sat stall u1", 32'(sc1), 32'd3);
        chk("stall u0", 32'(sc0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1); nxt();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("sat flush u1", 32'(fc1), 32'd3);
        chk("flush u0", 32'(fc0), 32'd5);
        nxt();

        // reset asserted during a stall
        drive(0, 0, 0, 0, 9, 1, 1, 0); nxt();
        drive(9, 0, 1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst stall visible", 32'(pc[0]), 32'd0);
        nxt();
        @(negedge clk);
        chk("rst clears stall", 32'(pc[0]), 32'd1);
        chk("rst clears bubble", 32'(bb[0]), 32'd0);
        chk("rst clears counts", 32'({sc0, fc0}), 32'd0);
        reset = 1'b0;
        nxt();

        // back-to-back loads to r4, then a use of r4
        drive(0, 0, 0, 0, 4, 1, 1, 0); nxt(); nxt();
        drive(4, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); chk("b2b stall", 32'(pc[0]), 32'd0); nxt();
        @(negedge clk); chk("b2b fwd younger", 32'(fa[0]), 32'd2); nxt();
        drive(0, 0, 0, 0, 0, 0, 0, 0); nxt(); nxt();

        done = 1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipeline. It runs in the reverse direction of the ID→EX pipeline register: it watches what is in flight in EX/MEM/WB and drives decisions back into ID and IF.
- Keeps its own registered shadow of destination info for the EX, MEM and WB slots.
- Drives the ID-stage operand-mux selects (muxA/muxB).
- Raises load-use stalls and branch flushes toward IF/ID and the ID/EX register.
- Keeps saturating stall and flush counters.

Parameters:
DELAY_SLOT, 1, 1 = branch delay slot architected (ID instruction survives a taken branch); 0 = squash ID too
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
id_rs  in  5  source register A of instruction in ID
id_rt  in  5  source register B of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  5  destination register of ID instruction (rd, rt or 31 already resolved)
id_rf_enable  in  1  ID instruction writes register file
id_load  in  1  ID instruction is a load
branch_taken  in  1  EX condition handler: branch/jump in EX is taken this cycle
fwd_a_sel  out  2  muxA select: 00 RF, 01 EX result, 10 MEM result (incl. load data), 11 WB result
fwd_b_sel  out  2  muxB select, same encoding
pc_enable  out  1  PC may advance
ifid_enable  out  1  IF/ID register may load
flush_ifid  out  1  IF/ID register loads NOP next edge
idex_bubble  out  1  ID/EX register loads all-zero control next edge
stall_count  out  CNT_W  cycles with load-use stall asserted, saturating
flush_count  out  CNT_W  cycles with branch flush asserted, saturating

Behaviour:
- Internal slots EX, MEM, WB each hold {valid, dest[4:0], rf_en, load}. A slot "writes R" iff valid & rf_en & dest==R & R!=0.
- Every edge (no reset):
  - WB<=MEM and MEM<=EX.
  - EX<=ID info, marked valid=1. EX instead gets valid=0 when idex_bubble=1.
- Forwarding, combinational, evaluated per operand with R=id_rs (A) or id_rt (B), only if the matching uses flag is set; otherwise sel=00.
  - Priority EX > MEM > WB.
  - EX slot writes R and is not a load → 01.
  - Else MEM writes R → 10.
  - Else WB writes R → 11.
  - Else 00. Register 0 always 00.
- Load-use hazard (lu): EX slot writes R, EX.load=1, and R is a used source of the ID instruction.
- Branch flush (br) = branch_taken.
- Outputs, combinational:
  - br=1: flush_ifid=1; idex_bubble=!DELAY_SLOT; pc_enable=1; ifid_enable=1; lu is ignored (flush wins).
  - Else lu=1: pc_enable=0; ifid_enable=0; idex_bubble=1; flush_ifid=0. Stall lasts exactly 1 cycle: next cycle the load is in MEM and is forwarded with 10.
  - Else: pc_enable=1, ifid_enable=1, flush_ifid=0, idex_bubble=0.
- While lu stalls, fwd_*_sel still reflects current slots; ID/EX discards the result via the bubble.
- Counters, at the edge:
  - stall_count += 1 when lu & !br.
  - flush_count += 1 when br.
  - Both saturate at all-ones; no wrap.
- Reset (synchronous): all slot valid bits=0, counters=0. Slot dest/flags are don't-care once invalid.
  - During and after reset, with no ID sources: fwd=00/00, pc_enable=1, ifid_enable=1, flush_ifid=0, idex_bubble=0, counts=0.
  - Reset mid-stall clears the EX slot, so the stall drops on the cycle after reset.
- Simultaneous: br and lu in the same cycle → only flush; stall_count unchanged.
- Back-to-back loads to the same register: the second load's use forwards from the younger slot (priority order).

Test Plan:
- Reset then idle with all inputs 0 → fwd 00/00, pc_enable=1, ifid_enable=1, counts 0 after reset.
- ADD r3 (id_dest=3, rf_en) followed next cycle by ID rs=3 → fwd_a_sel=01. One cycle later, rs=3 in a new ID instruction → 10. Two cycles later → 11.
- LW r5 followed by ID using rt=5 → pc_enable=0, ifid_enable=0, idex_bubble=1 for exactly 1 cycle; next cycle fwd_b_sel=10; stall_count=1.
- ID rs=0 while EX/MEM/WB all write r0 → fwd_a_sel=00, no stall.
- branch_taken=1 in the same cycle as a load-use hazard: DELAY_SLOT=1 → flush_ifid=1, idex_bubble=0, pc_enable=1, flush_count=1, stall_count=0; DELAY_SLOT=0 → idex_bubble=1.
- Force stall_count to 0xFFFE, then 3 load-use stalls → count holds at 0xFFFF. Assert reset during a stall → outputs return to defaults one edge later.
